// File: rtl/byte_add_pipe.sv
// rtl/byte_add_pipe.sv - streams a word region over Avalon-MM, adds a per-run addend to every byte, writes back in place
module byte_add_pipe #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 10,
    parameter int BYTE_CNT        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] length_i,
    input  logic [7:0]            addend_i,
    input  logic                  sat_mode_i,
    input  logic                  run_i,
    output logic                  waitrequest_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] amm_rd_address_o,
    output logic                  amm_rd_read_o,
    input  logic [DATA_WIDTH-1:0] amm_rd_readdata_i,
    input  logic                  amm_rd_readdatavalid_i,
    input  logic                  amm_rd_waitrequest_i,
    output logic [ADDR_WIDTH-1:0] amm_wr_address_o,
    output logic                  amm_wr_write_o,
    output logic [DATA_WIDTH-1:0] amm_wr_writedata_o,
    output logic [BYTE_CNT-1:0]   amm_wr_byteenable_o,
    input  logic                  amm_wr_waitrequest_i
);

    localparam int NW = ADDR_WIDTH + 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DONE = 2'd2} state_t;

    function automatic logic [DATA_WIDTH-1:0] add_bytes(input logic [DATA_WIDTH-1:0] w,
                                                         input logic [7:0] a, input logic sat);
        logic [8:0] s;
        add_bytes = '0;
        for (int k = 0; k < BYTE_CNT; k++) begin
            s = {1'b0, w[8*k +: 8]} + {1'b0, a};
            add_bytes[8*k +: 8] = (sat && s[8]) ? 8'hFF : s[7:0];
        end
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [NW-1:0]         nwords_q, nwords_d;
    logic [BYTE_CNT-1:0]   last_be_q, last_be_d;
    logic [7:0]            addend_q, addend_d;
    logic                  sat_q, sat_d;
    logic                  rd_read_q, rd_read_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [NW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]         credit_q, credit_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [MAX_OUTSTANDING];
    logic [DATA_WIDTH-1:0] fifo_mem_d [MAX_OUTSTANDING];
    logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
    logic                  wr_write_q, wr_write_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [BYTE_CNT-1:0]   wr_be_q, wr_be_d;
    logic [NW-1:0]         pop_cnt_q, pop_cnt_d;
    logic [NW-1:0]         wr_cnt_q, wr_cnt_d;

    // Run setup: word count clipped at the top of the address space
    logic [NW-1:0]       words_ceil, words_avail, words_run, rem;
    logic                clip;
    logic [BYTE_CNT-1:0] run_last_be;

    always_comb begin
        words_ceil  = ({1'b0, length_i} + NW'(BYTE_CNT - 1)) / NW'(BYTE_CNT);
        words_avail = NW'(2 ** ADDR_WIDTH) - {1'b0, base_addr_i};
        clip        = words_ceil > words_avail;
        words_run   = clip ? words_avail : words_ceil;
        rem         = {1'b0, length_i} % NW'(BYTE_CNT);
        for (int k = 0; k < BYTE_CNT; k++) begin
            run_last_be[k] = clip || (rem == '0) || (NW'(k) < rem);
        end
    end

    logic rd_acc, wr_acc, push, pop, launch;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        nwords_d   = nwords_q;
        last_be_d  = last_be_q;
        addend_d   = addend_q;
        sat_d      = sat_q;
        rd_read_d  = rd_read_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        credit_d   = credit_q;
        fifo_mem_d = fifo_mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_write_d = wr_write_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_be_d    = wr_be_q;
        pop_cnt_d  = pop_cnt_q;
        wr_cnt_d   = wr_cnt_q;

        rd_acc = rd_read_q && !amm_rd_waitrequest_i;
        wr_acc = wr_write_q && !amm_wr_waitrequest_i;
        push   = (state_q == S_ACTIVE) && amm_rd_readdatavalid_i;
        pop    = (state_q == S_ACTIVE) && (fifo_cnt_q != '0) && (!wr_write_q || wr_acc);
        // Credit counts every launched read until its write is accepted, so the FIFO cannot overflow
        launch = (state_q == S_ACTIVE) && (!rd_read_q || rd_acc) && (rd_cnt_q < nwords_q)
                 && (credit_q < CW'(MAX_OUTSTANDING));

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    base_d    = base_addr_i;
                    nwords_d  = words_run;
                    last_be_d = run_last_be;
                    addend_d  = addend_i;
                    sat_d     = sat_mode_i;
                    wptr_d    = '0;
                    rptr_d    = '0;
                    pop_cnt_d = '0;
                    wr_cnt_d  = '0;
                    if (length_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_ACTIVE;
                        rd_read_d = 1'b1;
                        rd_addr_d = base_addr_i;
                        rd_cnt_d  = NW'(1);
                        credit_d  = CW'(1);
                    end
                end
            end
            S_ACTIVE: begin
                if (rd_acc) rd_read_d = 1'b0;
                if (launch) begin
                    rd_read_d = 1'b1;
                    rd_addr_d = base_q + rd_cnt_q[ADDR_WIDTH-1:0];
                    rd_cnt_d  = rd_cnt_q + NW'(1);
                end
                credit_d = credit_q + CW'(launch) - CW'(wr_acc);
                if (push) begin
                    fifo_mem_d[wptr_q] = amm_rd_readdata_i;
                    wptr_d = (wptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PW'(1);
                end
                if (wr_acc) begin
                    wr_write_d = 1'b0;
                    wr_cnt_d   = wr_cnt_q + NW'(1);
                    if (wr_cnt_q + NW'(1) == nwords_q) state_d = S_DONE;
                end
                if (pop) begin
                    wr_write_d = 1'b1;
                    wr_data_d  = add_bytes(fifo_mem_q[rptr_q], addend_q, sat_q);
                    wr_addr_d  = base_q + pop_cnt_q[ADDR_WIDTH-1:0];
                    wr_be_d    = (pop_cnt_q == nwords_q - NW'(1)) ? last_be_q : '1;
                    pop_cnt_d  = pop_cnt_q + NW'(1);
                    rptr_d = (rptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PW'(1);
                end
                fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
            end
            S_DONE: begin
                state_d    = S_IDLE;
                rd_read_d  = 1'b0;
                rd_addr_d  = '0;
                wr_write_d = 1'b0;
                wr_addr_d  = '0;
                wr_data_d  = '0;
                wr_be_d    = '0;
                credit_d   = '0;
                fifo_cnt_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            nwords_q   <= '0;
            last_be_q  <= '0;
            addend_q   <= '0;
            sat_q      <= 1'b0;
            rd_read_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            credit_q   <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_mem_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
            wr_write_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_be_q    <= '0;
            pop_cnt_q  <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            nwords_q   <= nwords_d;
            last_be_q  <= last_be_d;
            addend_q   <= addend_d;
            sat_q      <= sat_d;
            rd_read_q  <= rd_read_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            credit_q   <= credit_d;
            fifo_mem_q <= fifo_mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_write_q <= wr_write_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_be_q    <= wr_be_d;
            pop_cnt_q  <= pop_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign waitrequest_o       = (state_q != S_IDLE);
    assign done_o              = (state_q == S_DONE);
    assign amm_rd_address_o    = rd_addr_q;
    assign amm_rd_read_o       = rd_read_q;
    assign amm_wr_address_o    = wr_addr_q;
    assign amm_wr_write_o      = wr_write_q;
    assign amm_wr_writedata_o  = wr_data_q;
    assign amm_wr_byteenable_o = wr_be_q;

endmodule

// File: tb/tb_byte_add_pipe.sv
// tb/tb_byte_add_pipe.sv - self-checking bench for byte_add_pipe with Avalon-MM slave models
module tb_byte_add_pipe;

    localparam int DW = 64;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          arst_n_i;
    logic [AW-1:0] base_addr_i, length_i;
    logic [7:0]    addend_i;
    logic          sat_mode_i, run_i;
    logic          waitrequest_o, done_o;
    logic [AW-1:0] amm_rd_address_o;
    logic          amm_rd_read_o;
    logic [DW-1:0] amm_rd_readdata_i;
    logic          amm_rd_readdatavalid_i, amm_rd_waitrequest_i;
    logic [AW-1:0] amm_wr_address_o;
    logic          amm_wr_write_o;
    logic [DW-1:0] amm_wr_writedata_o;
    logic [7:0]    amm_wr_byteenable_o;
    logic          amm_wr_waitrequest_i;

    always #5 clk = ~clk;

    byte_add_pipe dut (
        .clk_i(clk), .arst_n_i(arst_n_i), .base_addr_i(base_addr_i), .length_i(length_i),
        .addend_i(addend_i), .sat_mode_i(sat_mode_i), .run_i(run_i),
        .waitrequest_o(waitrequest_o), .done_o(done_o),
        .amm_rd_address_o(amm_rd_address_o), .amm_rd_read_o(amm_rd_read_o),
        .amm_rd_readdata_i(amm_rd_readdata_i), .amm_rd_readdatavalid_i(amm_rd_readdatavalid_i),
        .amm_rd_waitrequest_i(amm_rd_waitrequest_i),
        .amm_wr_address_o(amm_wr_address_o), .amm_wr_write_o(amm_wr_write_o),
        .amm_wr_writedata_o(amm_wr_writedata_o), .amm_wr_byteenable_o(amm_wr_byteenable_o),
        .amm_wr_waitrequest_i(amm_wr_waitrequest_i)
    );

    logic [63:0] mem [1024];
    int checks = 0, errors = 0;
    int rd_lat = 1, rd_wait_pct = 0, wr_wait_pct = 0, stall_left = 0;
    bit sb_en = 1'b1;
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, max_out = 0, next_rd = 0;
    int due_q[$], raddr_q[$], exp_addr[$];
    logic [63:0] exp_data[$];
    logic [7:0]  exp_be[$];
    logic [63:0] last_wr_data;
    logic [7:0]  last_wr_be;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_word(input logic [63:0] w, input int a, input bit sat);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            int s = int'(w[8*b +: 8]) + a;
            if (sat && s > 255) s = 255;
            r[8*b +: 8] = 8'(s % 256);
        end
        return r;
    endfunction

    // Builds the expected write list from the current memory image; returns word count
    task automatic prepare(input int base, input int len, input int add, input bit sat,
                           input int fill_mode, input logic [63:0] fill_val, output int n);
        bit clipped = 1'b0;
        n = (len + 7) / 8;
        if (base + n > 1024) begin
            n = 1024 - base;
            clipped = 1'b1;
        end
        exp_addr.delete(); exp_data.delete(); exp_be.delete();
        for (int i = 0; i < n; i++) begin
            logic [7:0] be = 8'hFF;
            mem[base+i] = fill_mode ? fill_val : {$urandom, $urandom};
            if (i == n - 1 && !clipped && (len % 8) != 0) be = 8'((1 << (len % 8)) - 1);
            exp_addr.push_back(base + i);
            exp_data.push_back(model_word(mem[base+i], add, sat));
            exp_be.push_back(be);
        end
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; max_out = 0; next_rd = base;
    endtask

    // Slave models: decide stalls at negedge and record what the next posedge will accept
    always @(negedge clk) begin
        cyc++;
        if (done_o) done_cnt++;
        if (!sb_en || !arst_n_i) begin
            amm_rd_waitrequest_i = 1'b0;
            amm_wr_waitrequest_i = 1'b0;
            amm_rd_readdatavalid_i = 1'b0;
            due_q.delete(); raddr_q.delete();
        end else begin
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                amm_rd_readdatavalid_i = 1'b1;
                amm_rd_readdata_i = mem[raddr_q[0]];
                void'(due_q.pop_front()); void'(raddr_q.pop_front());
            end else begin
                amm_rd_readdatavalid_i = 1'b0;
                amm_rd_readdata_i = {$urandom, $urandom};
            end
            amm_rd_waitrequest_i = ($urandom_range(99) < rd_wait_pct);
            if (amm_rd_read_o && !amm_rd_waitrequest_i) begin
                check("rd_addr", 64'(amm_rd_address_o), 64'(next_rd));
                next_rd++; rd_cnt++;
                due_q.push_back(cyc + rd_lat);
                raddr_q.push_back(int'(amm_rd_address_o));
            end
            if (stall_left > 0) begin
                amm_wr_waitrequest_i = 1'b1;
                stall_left--;
            end else begin
                amm_wr_waitrequest_i = ($urandom_range(99) < wr_wait_pct);
            end
            if (amm_wr_write_o && !amm_wr_waitrequest_i) begin
                if (exp_addr.size() == 0) begin
                    check("wr_extra", 64'(amm_wr_address_o), 64'hFFFF);
                end else begin
                    check("wr_addr", 64'(amm_wr_address_o), 64'(exp_addr[0]));
                    check("wr_data", amm_wr_writedata_o, exp_data[0]);
                    check("wr_be", 64'(amm_wr_byteenable_o), 64'(exp_be[0]));
                    void'(exp_addr.pop_front()); void'(exp_data.pop_front()); void'(exp_be.pop_front());
                end
                for (int b = 0; b < 8; b++)
                    if (amm_wr_byteenable_o[b]) mem[amm_wr_address_o][8*b +: 8] = amm_wr_writedata_o[8*b +: 8];
                last_wr_data = amm_wr_writedata_o;
                last_wr_be = amm_wr_byteenable_o;
                wr_cnt++;
            end
            if (rd_cnt - wr_cnt > max_out) max_out = rd_cnt - wr_cnt;
        end
    end

    task automatic start_run(input int base, input int len, input int add, input bit sat, input int n);
        @(negedge clk); #1;
        base_addr_i = AW'(base); length_i = AW'(len); addend_i = 8'(add); sat_mode_i = sat;
        run_i = 1'b1;
        @(negedge clk); #1;
        run_i = 1'b0;
        base_addr_i = AW'($urandom); length_i = AW'($urandom); addend_i = 8'($urandom);
        check("busy_after_run", 64'(waitrequest_o), 64'd1);
        if (n > 0) check("first_read", 64'(amm_rd_read_o), 64'd1);
        else check("len0_done", 64'(done_o), 64'd1);
    endtask

    task automatic run_case(input int base, input int len, input int add, input bit sat,
                            input int lat, input int rwp, input int wwp, input int stall,
                            input bit poke, input int fill_mode, input logic [63:0] fill_val);
        int n;
        rd_lat = lat; rd_wait_pct = rwp; wr_wait_pct = wwp;
        prepare(base, len, add, sat, fill_mode, fill_val, n);
        start_run(base, len, add, sat, n);
        for (int t = 0; t < 4000 && done_cnt == 0; t++) begin
            @(negedge clk); #1;
            if (t == 8) stall_left = stall;
            run_i = (poke && t == 3);
            base_addr_i = 10'h000; length_i = 10'd100;
        end
        run_i = 1'b0;
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("done_once", 64'(done_cnt), 64'd1);
        check("idle_after", 64'(waitrequest_o), 64'd0);
        check("n_reads", 64'(rd_cnt), 64'(n));
        check("n_writes", 64'(wr_cnt), 64'(n));
        check("exp_left", 64'(exp_addr.size()), 64'd0);
        check("max_outstanding", 64'(max_out <= 4), 64'd1);
    endtask

    initial begin
        int n;
        arst_n_i = 1'b0; run_i = 1'b0; base_addr_i = '0; length_i = '0; addend_i = '0; sat_mode_i = 1'b0;
        amm_rd_readdata_i = '0; amm_rd_readdatavalid_i = 1'b0;
        amm_rd_waitrequest_i = 1'b0; amm_wr_waitrequest_i = 1'b0;
        #1;
        check("rst_wait", 64'(waitrequest_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_rd", 64'({amm_rd_read_o, amm_rd_address_o}), 64'd0);
        check("rst_wr", 64'({amm_wr_write_o, amm_wr_address_o, amm_wr_byteenable_o}), 64'd0);
        check("rst_wdata", amm_wr_writedata_o, 64'd0);
        repeat (2) @(negedge clk);
        arst_n_i = 1'b1;

        run_case(16'h10, 20, 1, 1'b0, 1, 30, 30, 0, 1'b0, 1, 64'h0);
        check("t1_data", last_wr_data, 64'h0101010101010101);
        check("t1_be", 64'(last_wr_be), 64'h0F);

        run_case(16'h40, 8, 16'h10, 1'b1, 2, 0, 0, 0, 1'b0, 1, 64'h5624ff5863ff1f2e);
        check("t2_sat", last_wr_data, 64'h6634ff6873ff2f3e);
        run_case(16'h40, 8, 16'h10, 1'b0, 2, 0, 0, 0, 1'b0, 1, 64'h5624ff5863ff1f2e);
        check("t2_wrap", last_wr_data, 64'h66340f68730f2f3e);
        check("t2_be", 64'(last_wr_be), 64'hFF);

        run_case(16'h3fc, 45, 16'h33, 1'b0, 1, 20, 20, 0, 1'b0, 0, 64'h0);
        check("t3_be", 64'(last_wr_be), 64'hFF);

        run_case(16'h100, 64, $urandom_range(255), 1'($urandom), 5, 40, 40, 10, 1'b1, 0, 64'h0);

        run_case(16'h20, 0, 5, 1'b0, 1, 0, 0, 0, 1'b0, 0, 64'h0);

        // Abort a run once its second write is committed
        rd_lat = 1; rd_wait_pct = 0; wr_wait_pct = 0;
        prepare(16'h180, 64, 7, 1'b0, 0, 64'h0, n);
        start_run(16'h180, 64, 7, 1'b0, n);
        for (int t = 0; t < 200 && wr_cnt < 2; t++) begin
            @(negedge clk); #1;
        end
        check("mid_wr2", 64'(wr_cnt >= 2), 64'd1);
        #2;
        sb_en = 1'b0;
        arst_n_i = 1'b0;
        #1;
        check("abort_outs", 64'({amm_rd_read_o, amm_wr_write_o, waitrequest_o, done_o}), 64'd0);
        check("abort_addr", 64'({amm_rd_address_o, amm_wr_address_o}), 64'd0);
        done_cnt = 0;
        repeat (3) @(negedge clk);
        #1;
        check("abort_nodone", 64'(done_cnt), 64'd0);
        arst_n_i = 1'b1;
        sb_en = 1'b1;
        run_case(16'h200, 37, $urandom_range(255), 1'($urandom), 3, 25, 25, 0, 1'b0, 0, 64'h0);

        for (int i = 0; i < 3; i++)
            run_case($urandom_range(1023), $urandom_range(300, 1), $urandom_range(255), 1'($urandom),
                     $urandom_range(4, 1), 30, 30, 0, 1'b0, 0, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
